// File: rtl/lc2k_pkg.sv
// Shared opcode, state and mux-select encodings for the LC2K multi-cycle controller.
package lc2k_pkg;

    localparam logic [2:0] OP_ADD  = 3'd0;
    localparam logic [2:0] OP_NOR  = 3'd1;
    localparam logic [2:0] OP_LW   = 3'd2;
    localparam logic [2:0] OP_SW   = 3'd3;
    localparam logic [2:0] OP_BEQ  = 3'd4;
    localparam logic [2:0] OP_JALR = 3'd5;
    localparam logic [2:0] OP_HALT = 3'd6;
    localparam logic [2:0] OP_NOOP = 3'd7;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4,
        ST_HALT   = 3'd5
    } state_t;

    localparam logic [1:0] PC_SRC_PLUS1  = 2'd0;
    localparam logic [1:0] PC_SRC_BRANCH = 2'd1;
    localparam logic [1:0] PC_SRC_REGA   = 2'd2;

    localparam logic [1:0] WD_ALU  = 2'd0;
    localparam logic [1:0] WD_MDR  = 2'd1;
    localparam logic [1:0] WD_PC1  = 2'd2;

    localparam logic WR_REG_B    = 1'b0;
    localparam logic WR_REG_DEST = 1'b1;

endpackage

// File: rtl/lc2k_perf_counters.sv
// Free-running cycle and retired-instruction counters; both wrap at 2^CNT_W.
module lc2k_perf_counters
    import lc2k_pkg::*;
#(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             count_cycle,
    input  logic             count_instr,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] instr_cnt
);

    always_ff @(posedge clk) begin
        if (reset) begin
            cycle_cnt <= '0;
            instr_cnt <= '0;
        end else begin
            if (count_cycle) cycle_cnt <= cycle_cnt + CNT_W'(1);
            if (count_instr) instr_cnt <= instr_cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/lc2k_multicycle_ctrl.sv
// Multi-cycle LC2K sequencer driving datapath selects/strobes over a shared handshaked memory.
// Define LC2K_PERF_CNT_EN to add the cycle_cnt / instr_cnt performance counters.
module lc2k_multicycle_ctrl
    import lc2k_pkg::*;
`ifdef LC2K_PERF_CNT_EN
#(
    parameter int unsigned CNT_W = 32
)
`endif
(
    input  logic             clk,
    input  logic             reset,
    input  logic [2:0]       opcode,
    input  logic             alu_eq,
    input  logic             mem_ready,
    output logic             mem_req,
    output logic             mem_we,
    output logic             mem_addr_sel,
    output logic             ir_we,
    output logic             mdr_we,
    output logic             pc_we,
    output logic [1:0]       pc_src,
    output logic             alu_srcb,
    output logic             alu_op,
    output logic             reg_we,
    output logic             wr_reg_sel,
    output logic [1:0]       wr_data_sel,
    output logic             halted,
    output logic [2:0]       state
`ifdef LC2K_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] instr_cnt
`endif
);

    state_t state_q;
    state_t next_state;

    always_ff @(posedge clk) begin
        if (reset) state_q <= ST_FETCH;
        else       state_q <= next_state;
    end

    always_comb begin
        next_state   = state_q;
        mem_req      = 1'b0;
        mem_we       = 1'b0;
        mem_addr_sel = 1'b0;
        ir_we        = 1'b0;
        mdr_we       = 1'b0;
        pc_we        = 1'b0;
        pc_src       = PC_SRC_PLUS1;
        alu_srcb     = 1'b0;
        alu_op       = 1'b0;
        reg_we       = 1'b0;
        wr_reg_sel   = WR_REG_B;
        wr_data_sel  = WD_ALU;
        halted       = 1'b0;

        case (state_q)
            ST_FETCH: begin
                mem_req = 1'b1;
                if (mem_ready) begin
                    ir_we      = 1'b1;
                    pc_we      = 1'b1;
                    next_state = ST_DECODE;
                end
            end
            ST_DECODE: begin
                if (opcode == OP_HALT)      next_state = ST_HALT;
                else if (opcode == OP_NOOP) next_state = ST_FETCH;
                else                        next_state = ST_EXEC;
            end
            ST_EXEC: begin
                case (opcode)
                    OP_ADD, OP_NOR: begin
                        alu_op     = opcode[0];
                        next_state = ST_WB;
                    end
                    OP_LW, OP_SW: begin
                        alu_srcb   = 1'b1;
                        next_state = ST_MEM;
                    end
                    OP_BEQ: begin
                        if (alu_eq) begin
                            pc_we  = 1'b1;
                            pc_src = PC_SRC_BRANCH;
                        end
                        next_state = ST_FETCH;
                    end
                    OP_JALR: begin
                        // regA is read before this write lands, so jalr with regA == regB
                        // still jumps to the old regA value.
                        reg_we      = 1'b1;
                        wr_data_sel = WD_PC1;
                        pc_we       = 1'b1;
                        pc_src      = PC_SRC_REGA;
                        next_state  = ST_FETCH;
                    end
                    default: next_state = ST_FETCH;
                endcase
            end
            ST_MEM: begin
                mem_req      = 1'b1;
                mem_addr_sel = 1'b1;
                mem_we       = (opcode == OP_SW);
                if (mem_ready) begin
                    if (opcode == OP_LW) begin
                        mdr_we     = 1'b1;
                        next_state = ST_WB;
                    end else begin
                        next_state = ST_FETCH;
                    end
                end
            end
            ST_WB: begin
                reg_we = 1'b1;
                if (opcode == OP_LW) begin
                    wr_data_sel = WD_MDR;
                end else begin
                    wr_reg_sel = WR_REG_DEST;
                end
                next_state = ST_FETCH;
            end
            ST_HALT: halted = 1'b1;
            default: next_state = ST_FETCH;
        endcase

        // Reset squashes every output in the same cycle, abandoning any open request.
        if (reset) begin
            mem_req      = 1'b0;
            mem_we       = 1'b0;
            mem_addr_sel = 1'b0;
            ir_we        = 1'b0;
            mdr_we       = 1'b0;
            pc_we        = 1'b0;
            pc_src       = PC_SRC_PLUS1;
            alu_srcb     = 1'b0;
            alu_op       = 1'b0;
            reg_we       = 1'b0;
            wr_reg_sel   = WR_REG_B;
            wr_data_sel  = WD_ALU;
            halted       = 1'b0;
        end
    end

    assign state = reset ? 3'd0 : 3'(state_q);

`ifdef LC2K_PERF_CNT_EN
    logic             retire;
    logic [CNT_W-1:0] cycle_cnt_q;
    logic [CNT_W-1:0] instr_cnt_q;

    // An instruction retires when control returns to FETCH, or when halt is decoded.
    assign retire = ((state_q != ST_FETCH) && (next_state == ST_FETCH)) ||
                    ((state_q == ST_DECODE) && (next_state == ST_HALT));

    lc2k_perf_counters #(.CNT_W(CNT_W)) u_perf (
        .clk         (clk),
        .reset       (reset),
        .count_cycle (state_q != ST_HALT),
        .count_instr (retire),
        .cycle_cnt   (cycle_cnt_q),
        .instr_cnt   (instr_cnt_q)
    );

    assign cycle_cnt = reset ? '0 : cycle_cnt_q;
    assign instr_cnt = reset ? '0 : instr_cnt_q;
`endif

endmodule

// File: tb/tb_lc2k_multicycle_ctrl.sv
// Scoreboard bench for lc2k_multicycle_ctrl: per-cycle expected control vectors are queued and compared.
module tb_lc2k_multicycle_ctrl;
    import lc2k_pkg::*;

    typedef struct packed {
        logic [2:0] state;
        logic       halted;
        logic       mem_req;
        logic       mem_we;
        logic       mem_addr_sel;
        logic       ir_we;
        logic       mdr_we;
        logic       pc_we;
        logic [1:0] pc_src;
        logic       alu_srcb;
        logic       alu_op;
        logic       reg_we;
        logic       wr_reg_sel;
        logic [1:0] wr_data_sel;
    } ctrl_t;

    typedef struct packed {
        logic       rst;
        logic [2:0] op;
        logic       rdy;
        logic       eq;
        ctrl_t      exp;
    } step_t;

    logic       clk = 1'b0;
    logic       reset;
    logic [2:0] opcode;
    logic       alu_eq;
    logic       mem_ready;
    logic       mem_req, mem_we, mem_addr_sel, ir_we, mdr_we, pc_we;
    logic [1:0] pc_src;
    logic       alu_srcb, alu_op, reg_we, wr_reg_sel;
    logic [1:0] wr_data_sel;
    logic       halted;
    logic [2:0] state;
`ifdef LC2K_PERF_CNT_EN
    logic [31:0] cycle_cnt, instr_cnt;
`endif

    int    checks   = 0;
    int    failures = 0;
    ctrl_t exp_q[$];

    lc2k_multicycle_ctrl dut (
        .clk          (clk),
        .reset        (reset),
        .opcode       (opcode),
        .alu_eq       (alu_eq),
        .mem_ready    (mem_ready),
        .mem_req      (mem_req),
        .mem_we       (mem_we),
        .mem_addr_sel (mem_addr_sel),
        .ir_we        (ir_we),
        .mdr_we       (mdr_we),
        .pc_we        (pc_we),
        .pc_src       (pc_src),
        .alu_srcb     (alu_srcb),
        .alu_op       (alu_op),
        .reg_we       (reg_we),
        .wr_reg_sel   (wr_reg_sel),
        .wr_data_sel  (wr_data_sel),
        .halted       (halted),
        .state        (state)
`ifdef LC2K_PERF_CNT_EN
        ,
        .cycle_cnt    (cycle_cnt),
        .instr_cnt    (instr_cnt)
`endif
    );

    always #5 clk = ~clk;

    // Expected vectors per state, built straight from the state/output table.
    function automatic ctrl_t e_zero();
        ctrl_t e = '0;
        return e;
    endfunction

    function automatic ctrl_t e_fetch(logic rdy);
        ctrl_t e = '0;
        e.state = 3'd0; e.mem_req = 1'b1; e.ir_we = rdy; e.pc_we = rdy;
        return e;
    endfunction

    function automatic ctrl_t e_decode();
        ctrl_t e = '0;
        e.state = 3'd1;
        return e;
    endfunction

    function automatic ctrl_t e_exec(logic [2:0] op, logic eq);
        ctrl_t e = '0;
        e.state = 3'd2;
        if (op == 3'd1) e.alu_op = 1'b1;
        if (op == 3'd2 || op == 3'd3) e.alu_srcb = 1'b1;
        if (op == 3'd4 && eq) begin e.pc_we = 1'b1; e.pc_src = 2'd1; end
        if (op == 3'd5) begin
            e.reg_we = 1'b1; e.wr_data_sel = 2'd2; e.pc_we = 1'b1; e.pc_src = 2'd2;
        end
        return e;
    endfunction

    function automatic ctrl_t e_mem(logic [2:0] op, logic rdy);
        ctrl_t e = '0;
        e.state = 3'd3; e.mem_req = 1'b1; e.mem_addr_sel = 1'b1;
        e.mem_we = (op == 3'd3);
        e.mdr_we = rdy && (op == 3'd2);
        return e;
    endfunction

    function automatic ctrl_t e_wb(logic [2:0] op);
        ctrl_t e = '0;
        e.state = 3'd4; e.reg_we = 1'b1;
        if (op == 3'd2) e.wr_data_sel = 2'd1;
        else            e.wr_reg_sel  = 1'b1;
        return e;
    endfunction

    function automatic ctrl_t e_halt();
        ctrl_t e = '0;
        e.state = 3'd5; e.halted = 1'b1;
        return e;
    endfunction

    function automatic step_t mk(logic rst, logic [2:0] op, logic rdy, logic eq, ctrl_t e);
        step_t s;
        s.rst = rst; s.op = op; s.rdy = rdy; s.eq = eq; s.exp = e;
        return s;
    endfunction

    function automatic ctrl_t sample();
        ctrl_t o;
        o.state = state; o.halted = halted; o.mem_req = mem_req; o.mem_we = mem_we;
        o.mem_addr_sel = mem_addr_sel; o.ir_we = ir_we; o.mdr_we = mdr_we; o.pc_we = pc_we;
        o.pc_src = pc_src; o.alu_srcb = alu_srcb; o.alu_op = alu_op; o.reg_we = reg_we;
        o.wr_reg_sel = wr_reg_sel; o.wr_data_sel = wr_data_sel;
        return o;
    endfunction

    task automatic drive(input step_t s);
        reset = s.rst; opcode = s.op; mem_ready = s.rdy; alu_eq = s.eq;
        exp_q.push_back(s.exp);
    endtask

    task automatic test_reset();
        step_t s[$];
        ctrl_t got, want;
        s.push_back(mk(1, OP_ADD, 1, 1, e_zero()));
        s.push_back(mk(1, OP_SW, 1, 1, e_zero()));
        s.push_back(mk(0, OP_ADD, 0, 0, e_fetch(0)));
        foreach (s[i]) begin
            drive(s[i]);
            @(negedge clk);
            got = sample(); want = exp_q.pop_front(); checks++;
            if (got !== want) begin
                failures++; $display("[TB] FAIL reset[%0d] got=%h want=%h", i, got, want);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_add();
        step_t s[$];
        ctrl_t got, want;
        int pc_pulses = 0;
        s.push_back(mk(0, OP_ADD, 1, 0, e_fetch(1)));
        s.push_back(mk(0, OP_ADD, 1, 0, e_decode()));
        s.push_back(mk(0, OP_ADD, 1, 0, e_exec(OP_ADD, 0)));
        s.push_back(mk(0, OP_ADD, 1, 0, e_wb(OP_ADD)));
        s.push_back(mk(0, OP_NOR, 1, 1, e_fetch(1)));
        s.push_back(mk(0, OP_NOR, 0, 1, e_decode()));
        s.push_back(mk(0, OP_NOR, 0, 1, e_exec(OP_NOR, 1)));
        s.push_back(mk(0, OP_NOR, 0, 1, e_wb(OP_NOR)));
        foreach (s[i]) begin
            drive(s[i]);
            @(negedge clk);
            got = sample(); want = exp_q.pop_front(); checks++;
            if (got !== want) begin
                failures++; $display("[TB] FAIL add_nor[%0d] got=%h want=%h", i, got, want);
            end
            if (i < 4 && got.pc_we === 1'b1) pc_pulses++;
            @(posedge clk); #1;
        end
        checks++;
        if (pc_pulses !== 1) begin
            failures++; $display("[TB] FAIL add_pc_we_pulses got=%0d want=1", pc_pulses);
        end
    endtask

    task automatic test_lw_wait();
        step_t s[$];
        ctrl_t got, want;
        int req_cycles = 0, mdr_pulses = 0;
        s.push_back(mk(0, OP_LW, 1, 0, e_fetch(1)));
        s.push_back(mk(0, OP_LW, 1, 0, e_decode()));
        s.push_back(mk(0, OP_LW, 0, 0, e_exec(OP_LW, 0)));
        for (int k = 0; k < 3; k++) s.push_back(mk(0, OP_LW, 0, 0, e_mem(OP_LW, 0)));
        s.push_back(mk(0, OP_LW, 1, 0, e_mem(OP_LW, 1)));
        s.push_back(mk(0, OP_LW, 1, 0, e_wb(OP_LW)));
        foreach (s[i]) begin
            drive(s[i]);
            @(negedge clk);
            got = sample(); want = exp_q.pop_front(); checks++;
            if (got !== want) begin
                failures++; $display("[TB] FAIL lw_wait[%0d] got=%h want=%h", i, got, want);
            end
            if (got.mem_req === 1'b1 && got.mem_addr_sel === 1'b1) req_cycles++;
            if (got.mdr_we === 1'b1) mdr_pulses++;
            @(posedge clk); #1;
        end
        checks++;
        if (req_cycles !== 4 || mdr_pulses !== 1) begin
            failures++;
            $display("[TB] FAIL lw_handshake got req=%0d mdr=%0d want req=4 mdr=1", req_cycles, mdr_pulses);
        end
    endtask

    task automatic test_sw();
        step_t s[$];
        ctrl_t got, want;
        s.push_back(mk(0, OP_SW, 0, 0, e_fetch(0)));
        s.push_back(mk(0, OP_SW, 1, 0, e_fetch(1)));
        s.push_back(mk(0, OP_SW, 0, 0, e_decode()));
        s.push_back(mk(0, OP_SW, 1, 0, e_exec(OP_SW, 0)));
        s.push_back(mk(0, OP_SW, 0, 0, e_mem(OP_SW, 0)));
        s.push_back(mk(0, OP_SW, 1, 0, e_mem(OP_SW, 1)));
        foreach (s[i]) begin
            drive(s[i]);
            @(negedge clk);
            got = sample(); want = exp_q.pop_front(); checks++;
            if (got !== want) begin
                failures++; $display("[TB] FAIL sw[%0d] got=%h want=%h", i, got, want);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_branch_jump();
        step_t s[$];
        ctrl_t got, want;
        s.push_back(mk(0, OP_BEQ, 1, 1, e_fetch(1)));
        s.push_back(mk(0, OP_BEQ, 0, 1, e_decode()));
        s.push_back(mk(0, OP_BEQ, 0, 1, e_exec(OP_BEQ, 1)));
        s.push_back(mk(0, OP_BEQ, 1, 0, e_fetch(1)));
        s.push_back(mk(0, OP_BEQ, 0, 0, e_decode()));
        s.push_back(mk(0, OP_BEQ, 1, 0, e_exec(OP_BEQ, 0)));
        s.push_back(mk(0, OP_JALR, 1, 1, e_fetch(1)));
        s.push_back(mk(0, OP_JALR, 0, 1, e_decode()));
        s.push_back(mk(0, OP_JALR, 0, 1, e_exec(OP_JALR, 1)));
        s.push_back(mk(0, OP_NOOP, 1, 0, e_fetch(1)));
        s.push_back(mk(0, OP_NOOP, 1, 0, e_decode()));
        foreach (s[i]) begin
            drive(s[i]);
            @(negedge clk);
            got = sample(); want = exp_q.pop_front(); checks++;
            if (got !== want) begin
                failures++; $display("[TB] FAIL beq_jalr_noop[%0d] got=%h want=%h", i, got, want);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset_mid_request();
        step_t s[$];
        ctrl_t got, want;
        s.push_back(mk(0, OP_LW, 0, 0, e_fetch(0)));
        s.push_back(mk(1, OP_LW, 1, 0, e_zero()));
        s.push_back(mk(0, OP_LW, 1, 0, e_fetch(1)));
        s.push_back(mk(0, OP_LW, 0, 0, e_decode()));
        s.push_back(mk(0, OP_LW, 0, 0, e_exec(OP_LW, 0)));
        s.push_back(mk(0, OP_LW, 0, 0, e_mem(OP_LW, 0)));
        s.push_back(mk(1, OP_LW, 1, 0, e_zero()));
        s.push_back(mk(0, OP_ADD, 0, 0, e_fetch(0)));
        foreach (s[i]) begin
            drive(s[i]);
            @(negedge clk);
            got = sample(); want = exp_q.pop_front(); checks++;
            if (got !== want) begin
                failures++; $display("[TB] FAIL reset_mid_req[%0d] got=%h want=%h", i, got, want);
            end
            @(posedge clk); #1;
        end
    endtask

`ifdef LC2K_PERF_CNT_EN
    task automatic test_perf();
        step_t s[$];
        ctrl_t got, want;
        s.push_back(mk(1, OP_ADD, 1, 0, e_zero()));
        s.push_back(mk(0, OP_ADD, 1, 0, e_fetch(1)));
        s.push_back(mk(0, OP_ADD, 1, 0, e_decode()));
        s.push_back(mk(0, OP_ADD, 1, 0, e_exec(OP_ADD, 0)));
        s.push_back(mk(0, OP_ADD, 1, 0, e_wb(OP_ADD)));
        s.push_back(mk(0, OP_SW, 1, 0, e_fetch(1)));
        s.push_back(mk(0, OP_SW, 1, 0, e_decode()));
        s.push_back(mk(0, OP_SW, 1, 0, e_exec(OP_SW, 0)));
        s.push_back(mk(0, OP_SW, 1, 0, e_mem(OP_SW, 1)));
        s.push_back(mk(0, OP_NOOP, 1, 0, e_fetch(1)));
        s.push_back(mk(0, OP_NOOP, 1, 0, e_decode()));
        s.push_back(mk(0, OP_HALT, 1, 0, e_fetch(1)));
        s.push_back(mk(0, OP_HALT, 1, 0, e_decode()));
        for (int k = 0; k < 3; k++) s.push_back(mk(0, OP_HALT, k[0], 0, e_halt()));
        s.push_back(mk(1, OP_HALT, 0, 0, e_zero()));
        foreach (s[i]) begin
            drive(s[i]);
            @(negedge clk);
            got = sample(); want = exp_q.pop_front(); checks++;
            if (got !== want) begin
                failures++; $display("[TB] FAIL perf_seq[%0d] got=%h want=%h", i, got, want);
            end
            if (want.state == 3'd5) begin
                checks++;
                if (cycle_cnt !== 32'd12 || instr_cnt !== 32'd4) begin
                    failures++;
                    $display("[TB] FAIL perf_cnt[%0d] got cyc=%0d ins=%0d want cyc=12 ins=4", i, cycle_cnt, instr_cnt);
                end
            end
            @(posedge clk); #1;
        end
    endtask
`endif

    task automatic test_halt();
        step_t s[$];
        ctrl_t got, want;
        s.push_back(mk(0, OP_HALT, 1, 0, e_fetch(1)));
        s.push_back(mk(0, OP_HALT, 1, 0, e_decode()));
        for (int k = 0; k < 4; k++) s.push_back(mk(0, OP_HALT, ~k[0], k[1], e_halt()));
        s.push_back(mk(1, OP_HALT, 1, 0, e_zero()));
        s.push_back(mk(0, OP_ADD, 0, 0, e_fetch(0)));
        foreach (s[i]) begin
            drive(s[i]);
            @(negedge clk);
            got = sample(); want = exp_q.pop_front(); checks++;
            if (got !== want) begin
                failures++; $display("[TB] FAIL halt[%0d] got=%h want=%h", i, got, want);
            end
            @(posedge clk); #1;
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired got=timeout want=finish");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        reset = 1'b1; opcode = 3'd0; alu_eq = 1'b0; mem_ready = 1'b0;
        test_reset();
        test_add();
        test_lw_wait();
        test_sw();
        test_branch_jump();
        test_reset_mid_request();
`ifdef LC2K_PERF_CNT_EN
        test_perf();
`endif
        test_halt();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
